// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, requester ids and the
// default end of the host-visible address window.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_RR    = 2'd0,
        S_HLOCK = 2'd1,
        S_FORCE = 2'd2
    } arb_state_t;

    typedef enum logic {
        HOST = 1'b0,
        ENG  = 1'b1
    } req_id_t;

    localparam logic [10:0] MAX_ADDR_DEFAULT = 11'h62C;

endpackage

// File: rtl/mem_port_arbiter_hold_counter.sv
// Saturating count of consecutive locked host grants; at_max looks at the value
// being loaded this cycle so the FSM can force the engine in the very next slot.
module hold_counter #(
    parameter int MAX_HOLD = 16,
    localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // A clear with a simultaneous increment starts a new hold run at one.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = CNT_W'(inc);
        end else if (inc && (cnt != MAX_CNT)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    assign at_max = (cnt_nxt == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port coefficient/result SRAM between the Avalon host
// front end and the calc engine, with a host burst lock bounded by MAX_HOLD.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 11,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEFAULT,
    parameter int                MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_err,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic              m_cs,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    req_id_t    last;
    logic       h_in_range;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       at_max;

    assign h_in_range = (h_addr < MAX_ADDR);

    always_comb begin
        h_gnt = 1'b0;
        e_gnt = 1'b0;
        case (state)
            S_RR: begin
                if (h_req && e_req) begin
                    h_gnt = (last == ENG);
                    e_gnt = (last == HOST);
                end else begin
                    h_gnt = h_req;
                    e_gnt = e_req;
                end
            end
            S_HLOCK: begin
                h_gnt = h_req;
                e_gnt = e_req & ~h_req;
            end
            S_FORCE: begin
                e_gnt = e_req;
            end
            default: begin
                h_gnt = 1'b0;
                e_gnt = 1'b0;
            end
        endcase
    end

    // Out-of-range host accesses are consumed by the grant but never reach the SRAM.
    assign m_cs    = e_gnt | (h_gnt & h_in_range);
    assign m_we    = h_gnt ? h_we    : e_we;
    assign m_addr  = h_gnt ? h_addr  : e_addr;
    assign m_wdata = h_gnt ? h_wdata : e_wdata;
    assign h_rdata = m_rdata;
    assign e_rdata = m_rdata;

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b1;
        cnt_inc   = h_gnt & h_lock;
        case (state)
            S_RR: begin
                if (h_gnt && h_lock) begin
                    state_nxt = S_HLOCK;
                end
            end
            S_HLOCK: begin
                cnt_clr = e_gnt | ~h_lock;
                if (!h_lock) begin
                    state_nxt = S_RR;
                end else if (at_max && e_req) begin
                    state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                cnt_inc   = 1'b0;
                state_nxt = h_lock ? S_HLOCK : S_RR;
            end
            default: begin
                state_nxt = S_RR;
            end
        endcase
    end

    hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RR;
            last     <= ENG;
            h_rvalid <= 1'b0;
            e_rvalid <= 1'b0;
            h_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (h_gnt) begin
                last <= HOST;
            end else if (e_gnt) begin
                last <= ENG;
            end
            h_rvalid <= h_gnt & ~h_we & h_in_range;
            e_rvalid <= e_gnt & ~e_we;
            h_err    <= h_gnt & ~h_in_range;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected grants/read data/errors,
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req, h_we, h_lock;
    logic [10:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_gnt, h_rvalid, h_err;
    logic [31:0] h_rdata;
    logic        e_req, e_we;
    logic [10:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_gnt, e_rvalid;
    logic [31:0] e_rdata;
    logic        m_cs, m_we;
    logic [10:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    typedef struct {
        int          cyc;
        logic        hg;
        logic        cs;
        logic        we;
        logic [10:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    gnt_t gnt_q[$];
    rd_t  hrd_q[$];
    rd_t  erd_q[$];
    int   err_q[$];

    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;
    int   hi, ei;
    logic [10:0] ha, ea;

    logic [31:0] mem [0:2047];

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .h_req    (h_req),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_lock   (h_lock),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .h_err    (h_err),
        .e_req    (e_req),
        .e_we     (e_we),
        .e_addr   (e_addr),
        .e_wdata  (e_wdata),
        .e_gnt    (e_gnt),
        .e_rvalid (e_rvalid),
        .e_rdata  (e_rdata),
        .m_cs     (m_cs),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [10:0] a);
        return 32'hC0DE_0000 | {21'b0, a};
    endfunction

    // SRAM macro model: one-cycle read latency.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = pat(11'(i));
    end

    always @(posedge clk) begin
        if (m_cs) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportUnexpected(input string name);
        asserts++;
        fails++;
        $display("[TB] FAIL %s: got an event at cycle %0d, expected none", name, cyc);
    endtask

    task automatic expGnt(input logic hg, input logic cs, input logic we,
                          input logic [10:0] addr, input logic [31:0] wdata);
        gnt_t g;
        g.cyc = cyc; g.hg = hg; g.cs = cs; g.we = we; g.addr = addr; g.wdata = wdata;
        gnt_q.push_back(g);
    endtask

    task automatic expHrd(input logic [31:0] d);
        rd_t r;
        r.cyc = cyc + 1; r.data = d;
        hrd_q.push_back(r);
    endtask

    task automatic expErd(input logic [31:0] d);
        rd_t r;
        r.cyc = cyc + 1; r.data = d;
        erd_q.push_back(r);
    endtask

    task automatic expErr();
        err_q.push_back(cyc + 1);
    endtask

    task automatic applyStimulus(input logic hreq, input logic hwe, input logic [10:0] haddr,
                                 input logic [31:0] hwd, input logic hlock,
                                 input logic ereq, input logic ewe, input logic [10:0] eaddr,
                                 input logic [31:0] ewd);
        h_req = hreq; h_we = hwe; h_addr = haddr; h_wdata = hwd; h_lock = hlock;
        e_req = ereq; e_we = ewe; e_addr = eaddr; e_wdata = ewd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic hlock);
        applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, hlock, 1'b0, 1'b0, 11'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        gnt_t g;
        rd_t  r;
        int   ec;
        if (mon_en) begin
            if (h_gnt || e_gnt) begin
                if (gnt_q.size() == 0) begin
                    reportUnexpected("gnt_unexpected");
                end else begin
                    g = gnt_q.pop_front();
                    checkOutput("gnt_cycle", 64'(cyc), 64'(g.cyc));
                    checkOutput("gnt_who", {62'b0, h_gnt, e_gnt}, {62'b0, g.hg, ~g.hg});
                    checkOutput("m_cs", {63'b0, m_cs}, {63'b0, g.cs});
                    checkOutput("m_addr", {53'b0, m_addr}, {53'b0, g.addr});
                    checkOutput("m_we", {63'b0, m_we}, {63'b0, g.we});
                    if (g.we) checkOutput("m_wdata", {32'b0, m_wdata}, {32'b0, g.wdata});
                end
            end else if (m_cs) begin
                reportUnexpected("m_cs_without_gnt");
            end
            if (h_rvalid) begin
                if (hrd_q.size() == 0) begin
                    reportUnexpected("h_rvalid_unexpected");
                end else begin
                    r = hrd_q.pop_front();
                    checkOutput("h_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    checkOutput("h_rdata", {32'b0, h_rdata}, {32'b0, r.data});
                end
            end
            if (e_rvalid) begin
                if (erd_q.size() == 0) begin
                    reportUnexpected("e_rvalid_unexpected");
                end else begin
                    r = erd_q.pop_front();
                    checkOutput("e_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    checkOutput("e_rdata", {32'b0, e_rdata}, {32'b0, r.data});
                end
            end
            if (h_err) begin
                if (err_q.size() == 0) begin
                    reportUnexpected("h_err_unexpected");
                end else begin
                    ec = err_q.pop_front();
                    checkOutput("h_err_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_lock = 0;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Registered outputs cleared, no grants without requests.
        checkOutput("reset_h_rvalid", {63'b0, h_rvalid}, 64'd0);
        checkOutput("reset_e_rvalid", {63'b0, e_rvalid}, 64'd0);
        checkOutput("reset_h_err", {63'b0, h_err}, 64'd0);
        checkOutput("reset_h_gnt", {63'b0, h_gnt}, 64'd0);
        checkOutput("reset_e_gnt", {63'b0, e_gnt}, 64'd0);
        checkOutput("reset_m_cs", {63'b0, m_cs}, 64'd0);

        $display("[TB] first tie after reset");
        expGnt(1'b1, 1'b1, 1'b0, 11'h010, 32'h0); expHrd(pat(11'h010));
        applyStimulus(1'b1, 1'b0, 11'h010, 32'h0, 1'b0, 1'b1, 1'b0, 11'h020, 32'h0);
        expGnt(1'b0, 1'b1, 1'b0, 11'h020, 32'h0); expErd(pat(11'h020));
        applyStimulus(1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b1, 1'b0, 11'h020, 32'h0);
        idle(1'b0);

        $display("[TB] round-robin ties");
        hi = 0; ei = 0;
        for (int k = 0; k < 6; k++) begin
            ha = 11'h100 + 11'(hi);
            ea = 11'h200 + 11'(ei);
            if (k % 2 == 0) begin
                expGnt(1'b1, 1'b1, 1'b0, ha, 32'h0); expHrd(pat(ha));
            end else begin
                expGnt(1'b0, 1'b1, 1'b0, ea, 32'h0); expErd(pat(ea));
            end
            applyStimulus(1'b1, 1'b0, ha, 32'h0, 1'b0, 1'b1, 1'b0, ea, 32'h0);
            if (k % 2 == 0) hi++; else ei++;
        end
        idle(1'b0);

        $display("[TB] locked burst with forced engine slot");
        hi = 0;
        for (int k = 0; k < 21; k++) begin
            ha = 11'h300 + 11'(hi);
            ea = (k <= 16) ? 11'h040 : 11'h041;
            if (k == 16 || k == 20) begin
                expGnt(1'b0, 1'b1, 1'b0, ea, 32'h0); expErd(pat(ea));
            end else begin
                expGnt(1'b1, 1'b1, 1'b1, ha, 32'hBEEF_0000 | 32'(hi));
            end
            applyStimulus(k < 20, 1'b1, ha, 32'hBEEF_0000 | 32'(hi), k < 19,
                          1'b1, 1'b0, ea, 32'h0);
            if (k != 16 && k != 20) hi++;
        end
        idle(1'b0);
        expGnt(1'b1, 1'b1, 1'b0, 11'h305, 32'h0); expHrd(32'hBEEF_0005);
        applyStimulus(1'b1, 1'b0, 11'h305, 32'h0, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        idle(1'b0);

        $display("[TB] host address range boundary");
        expGnt(1'b1, 1'b1, 1'b0, 11'h62B, 32'h0); expHrd(pat(11'h62B));
        applyStimulus(1'b1, 1'b0, 11'h62B, 32'h0, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        expGnt(1'b1, 1'b0, 1'b1, 11'h62C, 32'h1234_5678); expErr();
        applyStimulus(1'b1, 1'b1, 11'h62C, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        expGnt(1'b1, 1'b0, 1'b0, 11'h7FF, 32'h0); expErr();
        applyStimulus(1'b1, 1'b0, 11'h7FF, 32'h0, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        idle(1'b0);

        $display("[TB] engine slot inside lock clears hold count");
        hi = 0;
        for (int k = 0; k < 21; k++) begin
            ha = 11'h500 + 11'(hi);
            ea = (k == 2) ? 11'h050 : 11'h051;
            if (k == 2 || k == 19) begin
                expGnt(1'b0, 1'b1, 1'b0, ea, 32'h0); expErd(pat(ea));
            end else begin
                expGnt(1'b1, 1'b1, 1'b1, ha, 32'hDA7A_0000 | 32'(hi));
            end
            applyStimulus(k != 2, 1'b1, ha, 32'hDA7A_0000 | 32'(hi), k < 20,
                          (k >= 2 && k <= 19), 1'b0, ea, 32'h0);
            if (k != 2 && k != 19) hi++;
        end
        idle(1'b0);

        $display("[TB] lock rising without host grant");
        expGnt(1'b1, 1'b1, 1'b0, 11'h080, 32'h0); expHrd(pat(11'h080));
        applyStimulus(1'b1, 1'b0, 11'h080, 32'h0, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
        idle(1'b1);
        expGnt(1'b0, 1'b1, 1'b0, 11'h082, 32'h0); expErd(pat(11'h082));
        applyStimulus(1'b1, 1'b0, 11'h081, 32'h0, 1'b1, 1'b1, 1'b0, 11'h082, 32'h0);
        expGnt(1'b1, 1'b1, 1'b0, 11'h081, 32'h0); expHrd(pat(11'h081));
        applyStimulus(1'b1, 1'b0, 11'h081, 32'h0, 1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
        idle(1'b0);

        $display("[TB] reset mid-operation");
        expGnt(1'b0, 1'b1, 1'b0, 11'h060, 32'h0); expErd(pat(11'h060));
        applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b0, 11'h060, 32'h0);
        rst = 1'b1;
        expGnt(1'b1, 1'b1, 1'b1, 11'h400, 32'h5555_AAAA);
        applyStimulus(1'b1, 1'b1, 11'h400, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
        rst = 1'b0;
        checkOutput("post_reset_e_rvalid", {63'b0, e_rvalid}, 64'd0);
        checkOutput("post_reset_h_err", {63'b0, h_err}, 64'd0);
        expGnt(1'b1, 1'b1, 1'b0, 11'h070, 32'h0); expHrd(pat(11'h070));
        applyStimulus(1'b1, 1'b0, 11'h070, 32'h0, 1'b0, 1'b1, 1'b0, 11'h071, 32'h0);
        expGnt(1'b0, 1'b1, 1'b0, 11'h071, 32'h0); expErd(pat(11'h071));
        applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b0, 11'h071, 32'h0);

        repeat (3) idle(1'b0);

        checkOutput("gnt_q_left", 64'(gnt_q.size()), 64'd0);
        checkOutput("hrd_q_left", 64'(hrd_q.size()), 64'd0);
        checkOutput("erd_q_left", 64'(erd_q.size()), 64'd0);
        checkOutput("err_q_left", 64'(err_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
